// File: rtl/csi_rx_link_ctrl.sv
// CSI-2 receive per-packet sequencer (word_clk domain): LP/HS entry,
// sync hunt, lane skew check, packet sizing, burst end and error counters.
//
// Ports:
//   clock, areset_n      word clock, async active-low reset
//   enable               0 forces IDLE on the next edge
//   lp_detect            lanes in LP state (level)
//   lanes_valid[LANES]   per-lane valid from the byte aligners
//   header_valid/long/len decoded packet header strobe and fields
//   word_strobe          one 32-bit word from the combiner
//   wait_for_sync        aligners/combiner hunt for sync
//   packet_done          1-cycle re-arm pulse at packet end
//   state_dbg            current state encoding
//   err_*_cnt            saturating skew/header-timeout/abort counters
module csi_rx_link_ctrl #(
  parameter int LANES       = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int SKEW_MAX    = 2,
  parameter int HDR_TIMEOUT = 8,
  parameter int MAX_LEN     = 8192
) (
  input  logic             clock,
  input  logic             areset_n,
  input  logic             enable,
  input  logic             lp_detect,
  input  logic [LANES-1:0] lanes_valid,
  input  logic             header_valid,
  input  logic             header_long,
  input  logic [15:0]      header_len,
  input  logic             word_strobe,
  output logic             wait_for_sync,
  output logic             packet_done,
  output logic [2:0]       state_dbg,
  output logic [7:0]       err_skew_cnt,
  output logic [7:0]       err_hdr_cnt,
  output logic [7:0]       err_abort_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_SYNC    = 3'd2,
    S_HEADER  = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DONE    = 3'd5,
    S_LP_WAIT = 3'd6
  } state_t;

  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]  SKEW_LIM  = 8'(SKEW_MAX);
  localparam logic [7:0]  HDR_LIM   = 8'(HDR_TIMEOUT);
  localparam logic [14:0] LEN_LIM15 = 15'(MAX_LEN);
  localparam logic [15:0] LEN_LIM   = 16'(MAX_LEN);
  localparam logic [15:0] PAY_LIM   = 16'(MAX_LEN * 2 - 1);

  state_t      r_state;
  logic [7:0]  r_settle;
  logic        r_skew_on;
  logic [7:0]  r_skew_cnt;
  logic [7:0]  r_hdr_cnt;
  logic [15:0] r_words;
  logic [15:0] r_pay_cyc;
  logic        r_wsync;
  logic        r_done;
  logic [7:0]  r_err_skew;
  logic [7:0]  r_err_hdr;
  logic [7:0]  r_err_abort;

  state_t      w_state;
  logic [7:0]  w_settle;
  logic        w_skew_on;
  logic [7:0]  w_skew_cnt;
  logic [7:0]  w_skew_now;
  logic [7:0]  w_hdr_cnt;
  logic [15:0] w_words;
  logic [15:0] w_pay_cyc;
  logic        w_inc_skew;
  logic        w_inc_hdr;
  logic        w_inc_abort;
  logic        w_live;
  logic        w_all;
  logic        w_any;
  logic [14:0] w_len_words;
  logic [15:0] w_words_ld;

  assign w_all = &lanes_valid;
  assign w_any = |lanes_valid;

  assign w_live = (r_state == S_SYNC)
               || (r_state == S_HEADER)
               || (r_state == S_PAYLOAD);

  // payload bytes + 2 CRC bytes, rounded up to whole 32-bit words
  assign w_len_words =
    15'(({1'b0, header_len} + 17'd5) >> 2);

  assign w_words_ld = (w_len_words > LEN_LIM15)
                    ? LEN_LIM
                    : {1'b0, w_len_words};

  // first lane-valid cycle counts as 0
  assign w_skew_now = r_skew_on ? (r_skew_cnt + 8'd1) : 8'd0;

  always_comb begin
    w_state     = r_state;
    w_settle    = r_settle;
    w_skew_on   = r_skew_on;
    w_skew_cnt  = r_skew_cnt;
    w_hdr_cnt   = r_hdr_cnt;
    w_words     = r_words;
    w_pay_cyc   = r_pay_cyc;
    w_inc_skew  = 1'b0;
    w_inc_hdr   = 1'b0;
    w_inc_abort = 1'b0;

    if (!enable) begin
      w_state = S_IDLE;
    end else if (w_live && lp_detect) begin
      // early LP return beats completion and timeouts
      w_state     = S_DONE;
      w_inc_abort = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_skew_on = 1'b0;
          if (!lp_detect) begin
            w_state  = S_SETTLE;
            w_settle = SETTLE_LD;
          end
        end
        S_SETTLE: begin
          w_skew_on = 1'b0;
          if (lp_detect) begin
            w_state = S_IDLE;
          end else if (r_settle == 8'd0) begin
            w_state = S_SYNC;
          end else begin
            w_settle = r_settle - 8'd1;
          end
        end
        S_SYNC: begin
          if (r_skew_on || w_any) begin
            w_skew_on  = 1'b1;
            w_skew_cnt = w_skew_now;
            if (w_all && (w_skew_now <= SKEW_LIM)) begin
              w_state   = S_HEADER;
              w_hdr_cnt = 8'd0;
            end else if (w_skew_now > SKEW_LIM) begin
              w_state    = S_DONE;
              w_inc_skew = 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (header_valid) begin
            if (header_long) begin
              w_state   = S_PAYLOAD;
              w_words   = w_words_ld;
              w_pay_cyc = 16'd0;
            end else begin
              w_state = S_DONE;
            end
          end else if (r_hdr_cnt == HDR_LIM) begin
            w_state   = S_DONE;
            w_inc_hdr = 1'b1;
          end else begin
            w_hdr_cnt = r_hdr_cnt + 8'd1;
          end
        end
        S_PAYLOAD: begin
          w_pay_cyc = r_pay_cyc + 16'd1;
          if (word_strobe) begin
            w_words = r_words - 16'd1;
          end
          if (word_strobe && (r_words == 16'd1)) begin
            w_state = S_DONE;
          end else if (r_pay_cyc == PAY_LIM) begin
            w_state = S_DONE;
          end
        end
        S_DONE: begin
          w_state = lp_detect ? S_IDLE : S_LP_WAIT;
        end
        S_LP_WAIT: begin
          if (lp_detect) begin
            w_state = S_IDLE;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= S_IDLE;
      r_settle    <= 8'd0;
      r_skew_on   <= 1'b0;
      r_skew_cnt  <= 8'd0;
      r_hdr_cnt   <= 8'd0;
      r_words     <= 16'd0;
      r_pay_cyc   <= 16'd0;
      r_wsync     <= 1'b1;
      r_done      <= 1'b0;
      r_err_skew  <= 8'd0;
      r_err_hdr   <= 8'd0;
      r_err_abort <= 8'd0;
    end else begin
      r_state    <= w_state;
      r_settle   <= w_settle;
      r_skew_on  <= w_skew_on;
      r_skew_cnt <= w_skew_cnt;
      r_hdr_cnt  <= w_hdr_cnt;
      r_words    <= w_words;
      r_pay_cyc  <= w_pay_cyc;
      r_wsync    <= (w_state == S_IDLE)
                 || (w_state == S_SETTLE)
                 || (w_state == S_SYNC);
      r_done     <= (w_state == S_DONE);
      if (w_inc_skew && (r_err_skew != 8'hFF)) begin
        r_err_skew <= r_err_skew + 8'd1;
      end
      if (w_inc_hdr && (r_err_hdr != 8'hFF)) begin
        r_err_hdr <= r_err_hdr + 8'd1;
      end
      if (w_inc_abort && (r_err_abort != 8'hFF)) begin
        r_err_abort <= r_err_abort + 8'd1;
      end
    end
  end

  assign wait_for_sync = r_wsync;
  assign packet_done   = r_done;
  assign state_dbg     = r_state;
  assign err_skew_cnt  = r_err_skew;
  assign err_hdr_cnt   = r_err_hdr;
  assign err_abort_cnt = r_err_abort;

endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// Directed bench for csi_rx_link_ctrl: expected error-counter values
// are queued per packet and checked on each packet_done pulse.
module tb_csi_rx_link_ctrl;

  logic       clock = 1'b0;
  logic       areset_n;
  logic       enable;
  logic       lp_detect;
  logic [1:0] lanes_valid;
  logic       header_valid;
  logic       header_long;
  logic [15:0] header_len;
  logic       word_strobe;
  logic       wait_for_sync;
  logic       packet_done;
  logic [2:0] state_dbg;
  logic [7:0] err_skew_cnt;
  logic [7:0] err_hdr_cnt;
  logic [7:0] err_abort_cnt;

  typedef struct packed {
    logic [7:0] sk;
    logic [7:0] hd;
    logic [7:0] ab;
  } exp_t;

  exp_t sb[$];
  logic [7:0] m_sk = 8'd0;
  logic [7:0] m_hd = 8'd0;
  logic [7:0] m_ab = 8'd0;
  int n_tests = 0;
  int n_fail  = 0;

  csi_rx_link_ctrl #(
    .LANES(2), .SETTLE_CYC(4), .SKEW_MAX(2),
    .HDR_TIMEOUT(8), .MAX_LEN(8192)
  ) dut (
    .clock         (clock),
    .areset_n      (areset_n),
    .enable        (enable),
    .lp_detect     (lp_detect),
    .lanes_valid   (lanes_valid),
    .header_valid  (header_valid),
    .header_long   (header_long),
    .header_len    (header_len),
    .word_strobe   (word_strobe),
    .wait_for_sync (wait_for_sync),
    .packet_done   (packet_done),
    .state_dbg     (state_dbg),
    .err_skew_cnt  (err_skew_cnt),
    .err_hdr_cnt   (err_hdr_cnt),
    .err_abort_cnt (err_abort_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v,
                                     input bit inc);
    if (inc && v != 8'hFF) return v + 8'd1;
    return v;
  endfunction

  task automatic expect_pkt(input bit sk, input bit hd,
                            input bit ab);
    exp_t e;
    m_sk = sat(m_sk, sk);
    m_hd = sat(m_hd, hd);
    m_ab = sat(m_ab, ab);
    e.sk = m_sk;
    e.hd = m_hd;
    e.ab = m_ab;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    if (packet_done === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pd_skew", 32'(err_skew_cnt), 32'(e.sk));
        chk("pd_hdr", 32'(err_hdr_cnt), 32'(e.hd));
        chk("pd_abort", 32'(err_abort_cnt), 32'(e.ab));
      end
    end
  endtask

  task automatic to_sync();
    lp_detect    = 1'b0;
    lanes_valid  = 2'b00;
    header_valid = 1'b0;
    word_strobe  = 1'b0;
    repeat (5) tick();
  endtask

  task automatic to_header();
    to_sync();
    lanes_valid = 2'b11;
    tick();
    lanes_valid = 2'b00;
  endtask

  task automatic send_hdr(input bit lng, input logic [15:0] len);
    header_valid = 1'b1;
    header_long  = lng;
    header_len   = len;
    tick();
    header_valid = 1'b0;
  endtask

  task automatic lp_return();
    lp_detect = 1'b1;
    tick();
  endtask

  initial begin
    areset_n     = 1'b0;
    enable       = 1'b1;
    lp_detect    = 1'b1;
    lanes_valid  = 2'b00;
    header_valid = 1'b0;
    header_long  = 1'b0;
    header_len   = 16'd0;
    word_strobe  = 1'b0;
    #22;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_wsync", 32'(wait_for_sync), 32'd1);
    chk("rst_pd", 32'(packet_done), 32'd0);
    chk("rst_cnt", {8'd0, err_skew_cnt, err_hdr_cnt,
                    err_abort_cnt}, 32'd0);
    areset_n = 1'b1;
    tick();
    chk("idle_lp", 32'(state_dbg), 32'd0);

    // long packet, 10 bytes -> 3 words
    to_sync();
    chk("t1_sync", 32'(state_dbg), 32'd2);
    chk("t1_sync_ws", 32'(wait_for_sync), 32'd1);
    lanes_valid = 2'b11;
    tick();
    lanes_valid = 2'b00;
    chk("t1_hdr", 32'(state_dbg), 32'd3);
    chk("t1_hdr_ws", 32'(wait_for_sync), 32'd0);
    send_hdr(1'b1, 16'd10);
    chk("t1_pay", 32'(state_dbg), 32'd4);
    word_strobe = 1'b1;
    tick();
    tick();
    chk("t1_pay2", 32'(state_dbg), 32'd4);
    expect_pkt(0, 0, 0);
    tick();
    word_strobe = 1'b0;
    chk("t1_done", 32'(state_dbg), 32'd5);
    chk("t1_pd", 32'(packet_done), 32'd1);
    tick();
    chk("t1_lpw", 32'(state_dbg), 32'd6);
    chk("t1_pd_off", 32'(packet_done), 32'd0);
    chk("t1_lpw_ws", 32'(wait_for_sync), 32'd0);
    lp_return();
    chk("t1_idle", 32'(state_dbg), 32'd0);
    chk("t1_idle_ws", 32'(wait_for_sync), 32'd1);

    // short packet
    to_header();
    expect_pkt(0, 0, 0);
    send_hdr(1'b0, 16'd4);
    chk("t2_done", 32'(state_dbg), 32'd5);
    word_strobe = 1'b1;
    lp_return();
    word_strobe = 1'b0;
    chk("t2_idle", 32'(state_dbg), 32'd0);
    chk("t2_pd_off", 32'(packet_done), 32'd0);

    // skew of 3 cycles fails
    to_sync();
    lanes_valid = 2'b01;
    repeat (3) tick();
    chk("t3_wait", 32'(state_dbg), 32'd2);
    lanes_valid = 2'b11;
    expect_pkt(1, 0, 0);
    tick();
    lanes_valid = 2'b00;
    chk("t3_fail", 32'(state_dbg), 32'd5);
    lp_return();

    // skew of 2 cycles passes
    to_sync();
    lanes_valid = 2'b01;
    repeat (2) tick();
    lanes_valid = 2'b11;
    tick();
    lanes_valid = 2'b00;
    chk("t3_pass", 32'(state_dbg), 32'd3);
    expect_pkt(0, 0, 0);
    send_hdr(1'b0, 16'd0);
    lp_return();

    // zero-length long packet still carries the CRC word
    to_header();
    send_hdr(1'b1, 16'd0);
    chk("len0_pay", 32'(state_dbg), 32'd4);
    word_strobe = 1'b1;
    expect_pkt(0, 0, 0);
    tick();
    word_strobe = 1'b0;
    chk("len0_done", 32'(state_dbg), 32'd5);
    lp_return();

    // header timeout
    to_header();
    repeat (8) tick();
    chk("t4_wait", 32'(state_dbg), 32'd3);
    expect_pkt(0, 1, 0);
    tick();
    chk("t4_to", 32'(state_dbg), 32'd5);
    lp_return();
    for (int i = 0; i < 300; i++) begin
      to_header();
      expect_pkt(0, 1, 0);
      repeat (9) tick();
      lp_return();
    end
    chk("t4_sat", 32'(err_hdr_cnt), 32'hFF);

    // LP return on the final word is an abort
    to_header();
    send_hdr(1'b1, 16'd10);
    word_strobe = 1'b1;
    repeat (2) tick();
    lp_detect = 1'b1;
    expect_pkt(0, 0, 1);
    tick();
    word_strobe = 1'b0;
    chk("t5_done", 32'(state_dbg), 32'd5);
    chk("t5_ab", 32'(err_abort_cnt), 32'd1);
    tick();
    chk("t5_idle", 32'(state_dbg), 32'd0);
    chk("t5_pd_off", 32'(packet_done), 32'd0);

    // oversize length clamps to MAX_LEN words
    to_header();
    send_hdr(1'b1, 16'hFFFF);
    word_strobe = 1'b1;
    repeat (8191) tick();
    chk("clamp_wait", 32'(state_dbg), 32'd4);
    expect_pkt(0, 0, 0);
    tick();
    word_strobe = 1'b0;
    chk("clamp_done", 32'(state_dbg), 32'd5);
    lp_return();

    // payload cycle timeout after MAX_LEN*2 cycles
    to_header();
    send_hdr(1'b1, 16'd100);
    repeat (16383) tick();
    chk("pto_wait", 32'(state_dbg), 32'd4);
    expect_pkt(0, 0, 0);
    tick();
    chk("pto_done", 32'(state_dbg), 32'd5);
    lp_return();

    // enable low in HEADER
    to_header();
    chk("t6_hdr", 32'(state_dbg), 32'd3);
    enable = 1'b0;
    tick();
    chk("t6_en_idle", 32'(state_dbg), 32'd0);
    chk("t6_en_pd", 32'(packet_done), 32'd0);
    chk("t6_en_ws", 32'(wait_for_sync), 32'd1);
    chk("t6_en_hold", 32'(err_hdr_cnt), 32'(m_hd));
    tick();
    chk("t6_en_stay", 32'(state_dbg), 32'd0);
    enable = 1'b1;

    // async reset mid-payload
    to_header();
    send_hdr(1'b1, 16'd10);
    word_strobe = 1'b1;
    tick();
    chk("t6_pay", 32'(state_dbg), 32'd4);
    #1;
    areset_n = 1'b0;
    #1;
    chk("t6_rst_st", 32'(state_dbg), 32'd0);
    chk("t6_rst_ws", 32'(wait_for_sync), 32'd1);
    chk("t6_rst_pd", 32'(packet_done), 32'd0);
    chk("t6_rst_cnt", {8'd0, err_skew_cnt, err_hdr_cnt,
                       err_abort_cnt}, 32'd0);
    word_strobe = 1'b0;
    lp_detect   = 1'b1;
    #10;
    areset_n = 1'b1;
    tick();
    chk("t6_after", 32'(state_dbg), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
